// File: rtl/iq_pkg.sv
// Shared definitions for the decoder and instruction queue.
// Covers base-word field positions, the reserved opcode and the decoder FSM encoding.
package iq_pkg;

  localparam int unsigned WORD_W = 32;

  localparam int unsigned MAJOR_HI   = 31;
  localparam int unsigned MAJOR_LO   = 28;
  localparam int unsigned SRC1_HI    = 27;
  localparam int unsigned SRC1_LO    = 23;
  localparam int unsigned SRC2_HI    = 22;
  localparam int unsigned SRC2_LO    = 18;
  localparam int unsigned SCALE_HI   = 17;
  localparam int unsigned SCALE_LO   = 16;
  localparam int unsigned DEST_HI    = 15;
  localparam int unsigned DEST_LO    = 11;
  localparam int unsigned MINOR_HI   = 10;
  localparam int unsigned MINOR_LO   = 7;
  localparam int unsigned HAS_ADDR_B = 6;
  localparam int unsigned OFF_SUB_B  = 5;

  localparam logic [3:0] RESERVED_MAJOR = 4'hF;
  localparam logic [7:0] DROP_CNT_MAX   = 8'hFF;

  typedef enum logic [1:0] {
    ST_BASE   = 2'd0,
    ST_EXT_HI = 2'd1,
    ST_EXT_LO = 2'd2
  } dec_state_t;

  typedef struct packed {
    logic [3:0] major;
    logic [4:0] src1;
    logic [4:0] src2;
    logic [1:0] scale;
    logic [4:0] dest;
    logic [3:0] minor;
    logic       has_address;
    logic       offset_sub;
  } iq_fields_t;

endpackage

// File: rtl/iq_out_reg.sv
// Output holding register towards the instruction queue.
// A load wins over a drain so back-to-back instructions leave no bubble.
module iq_out_reg
  import iq_pkg::*;
#(
  parameter int unsigned ADDR_W = 48
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_load,
  input  logic              i_drain,
  input  iq_fields_t        i_fields,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              o_valid,
  output iq_fields_t        o_fields,
  output logic [ADDR_W-1:0] o_addr
);

  logic              r_valid;
  iq_fields_t        r_fields;
  logic [ADDR_W-1:0] r_addr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid  <= 1'b0;
      r_fields <= '0;
      r_addr   <= '0;
    end else if (i_load) begin
      r_valid  <= 1'b1;
      r_fields <= i_fields;
      r_addr   <= i_addr;
    end else if (i_drain) begin
      r_valid  <= 1'b0;
    end
  end

  assign o_valid  = r_valid;
  assign o_fields = r_fields;
  assign o_addr   = r_addr;

endmodule

// File: rtl/instruction_decoder.sv
// Decodes fetch words (base word plus optional two address extension words)
// into registered instruction fields for the instruction queue.
module instruction_decoder
  import iq_pkg::*;
#(
  parameter int unsigned ADDR_W = 48
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       fetch_word,
  input  logic              fetch_valid,
  output logic              fetch_stall,
  input  logic              iq_full,
  output logic [3:0]        MajorOpcode_out,
  output logic [4:0]        Source1_out,
  output logic [4:0]        Source2_out,
  output logic [1:0]        OffsetScale_out,
  output logic [4:0]        Destination_out,
  output logic [3:0]        MinorOpcode_out,
  output logic [0:0]        HasAddress_out,
  output logic [ADDR_W-1:0] Address_out,
  output logic [0:0]        OffsetSub_out,
  output logic              Valid_out,
  output logic [7:0]        DropCount_out
);

  dec_state_t         r_state;
  iq_fields_t         r_pend;
  logic [ADDR_W-33:0] r_addr_hi;
  logic [7:0]         r_drop_cnt;

  iq_fields_t         w_base;
  iq_fields_t         w_load_fields;
  iq_fields_t         w_out_fields;
  logic [ADDR_W-1:0]  w_load_addr;
  logic [ADDR_W-1:0]  w_out_addr;
  logic               w_out_valid;
  logic               w_consume;
  logic               w_reserved;
  logic               w_load;
  logic               w_drain;

  always_comb begin
    w_base             = '0;
    w_base.major       = fetch_word[MAJOR_HI:MAJOR_LO];
    w_base.src1        = fetch_word[SRC1_HI:SRC1_LO];
    w_base.src2        = fetch_word[SRC2_HI:SRC2_LO];
    w_base.scale       = fetch_word[SCALE_HI:SCALE_LO];
    w_base.dest        = fetch_word[DEST_HI:DEST_LO];
    w_base.minor       = fetch_word[MINOR_HI:MINOR_LO];
    w_base.has_address = fetch_word[HAS_ADDR_B];
    w_base.offset_sub  = fetch_word[OFF_SUB_B];
  end

  assign fetch_stall = w_out_valid & iq_full;
  assign w_consume   = fetch_valid & ~fetch_stall;
  assign w_drain     = w_out_valid & ~iq_full;
  assign w_reserved  = (w_base.major == RESERVED_MAJOR);

  // Only a plain base word or the final extension word completes an instruction.
  always_comb begin
    w_load        = 1'b0;
    w_load_fields = w_base;
    w_load_addr   = '0;
    case (r_state)
      ST_BASE: begin
        w_load = w_consume & ~w_reserved & ~w_base.has_address;
      end
      ST_EXT_LO: begin
        w_load        = w_consume;
        w_load_fields = r_pend;
        w_load_addr   = {r_addr_hi, fetch_word};
      end
      default: begin
        w_load = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_BASE;
      r_pend     <= '0;
      r_addr_hi  <= '0;
      r_drop_cnt <= '0;
    end else if (w_consume) begin
      case (r_state)
        ST_BASE: begin
          if (w_reserved) begin
            if (r_drop_cnt != DROP_CNT_MAX) begin
              r_drop_cnt <= r_drop_cnt + 8'd1;
            end
          end else if (w_base.has_address) begin
            r_pend  <= w_base;
            r_state <= ST_EXT_HI;
          end
        end
        ST_EXT_HI: begin
          r_addr_hi <= fetch_word[ADDR_W-33:0];
          r_state   <= ST_EXT_LO;
        end
        ST_EXT_LO: begin
          r_state <= ST_BASE;
        end
        default: begin
          r_state <= ST_BASE;
        end
      endcase
    end
  end

  iq_out_reg #(
    .ADDR_W(ADDR_W)
  ) u_out_reg (
    .clk      (clk),
    .rst      (rst),
    .i_load   (w_load),
    .i_drain  (w_drain),
    .i_fields (w_load_fields),
    .i_addr   (w_load_addr),
    .o_valid  (w_out_valid),
    .o_fields (w_out_fields),
    .o_addr   (w_out_addr)
  );

  assign Valid_out       = w_out_valid;
  assign MajorOpcode_out = w_out_fields.major;
  assign Source1_out     = w_out_fields.src1;
  assign Source2_out     = w_out_fields.src2;
  assign OffsetScale_out = w_out_fields.scale;
  assign Destination_out = w_out_fields.dest;
  assign MinorOpcode_out = w_out_fields.minor;
  assign HasAddress_out  = w_out_fields.has_address;
  assign OffsetSub_out   = w_out_fields.offset_sub;
  assign Address_out     = w_out_addr;
  assign DropCount_out   = r_drop_cnt;

endmodule

// File: doc/instruction_decoder.md
INSTRUCTION_DECODER -- requirements
Module: instruction_decoder

Interface
REQ-001 SHALL have parameter ADDR_W, default 48, meaning address field width; only 48 is supported, and the high extension word carries ADDR_W-32 bits.
REQ-002 SHALL have port clk, input, 1, the single clock; all state is updated on its rising edge.
REQ-003 SHALL have port rst, input, 1; reset is asynchronous and active-high.
REQ-004 SHALL have port fetch_word, input, 32, the instruction or extension word from fetch.
REQ-005 SHALL have port fetch_valid, input, 1, meaning fetch_word is valid this cycle.
REQ-006 SHALL have port fetch_stall, output, 1, meaning the decoder does not consume fetch_word this cycle.
REQ-007 SHALL have port iq_full, input, 1, the backpressure signal from the instruction queue.
REQ-008 SHALL have the following outputs to the instruction queue, all registered:
- MajorOpcode_out [3:0], Source1_out [4:0], Source2_out [4:0], OffsetScale_out [1:0]
- Destination_out [4:0], MinorOpcode_out [3:0], HasAddress_out [0:0], Address_out [ADDR_W-1:0], OffsetSub_out [0:0]
REQ-009 SHALL have port Valid_out, output, 1, meaning the output fields hold a decoded instruction.
REQ-010 SHALL have port DropCount_out, output, 8, a saturating count of dropped reserved-opcode words.

Function
REQ-011 SHALL decode the base word as follows:
- major [31:28], src1 [27:23], src2 [22:18], scale [17:16]
- dest [15:11], minor [10:7], has_address [6], offset_sub [5]
- bits [4:0] ignored.
REQ-012 SHALL consume a word exactly on cycles where fetch_valid=1 and fetch_stall=0.
REQ-013 SHALL drive fetch_stall = Valid_out & iq_full; the output register drains on any edge where Valid_out=1 and iq_full=0.
REQ-014 SHALL implement FSM states BASE, EXT_HI and EXT_LO; the reset state is BASE.
REQ-015 BASE, base word consumed with has_address=0: load outputs with Address_out=0 and set Valid_out at the next edge (1-cycle latency); stay in BASE.
REQ-016 BASE, base word consumed with has_address=1: latch the fields into a pending register and go to EXT_HI; Valid_out is unaffected.
REQ-017 EXT_HI, word consumed: latch word[15:0] as addr[47:32] (word[31:16] ignored); go to EXT_LO.
REQ-018 EXT_LO, word consumed: addr[31:0]=word; load pending fields and address into the outputs; set Valid_out; go to BASE.
REQ-019 Without a consumed word the FSM SHALL hold its state; fetch_valid gaps between extension words are legal.
REQ-020 Drain without a new load SHALL clear Valid_out at that edge; drain and load in the same edge SHALL load the new instruction, so no bubble is inserted.
REQ-021 While fetch_stall=1, all output fields SHALL hold their values.
REQ-022 A base word with major=4'b1111 SHALL be consumed and discarded with no output and no state change; DropCount_out increments and saturates at 255.
REQ-023 Only base words SHALL be checked for the reserved opcode; an extension word is never dropped.

Reset
REQ-024 On rst, asynchronously: FSM=BASE, Valid_out=0, all output fields=0, DropCount_out=0, pending register=0, fetch_stall=0.
REQ-025 rst during EXT_HI or EXT_LO SHALL discard the partial instruction; the first word after reset is treated as a base word.

Structure
REQ-026 Field bit positions, the reserved opcode value and the FSM state encoding SHALL live in a shared package, iq_pkg, that is also used by instruction_queue.
REQ-027 The output holding register SHALL be one sub-module, iq_out_reg, with load, drain, and a valid flag.

Verification
REQ-028 Address instruction: words 0xAFBBDCE0, 0x00000000, 0x00000062 on consecutive cycles, iq_full=0 -> the cycle after the third word shows Valid_out=1, MajorOpcode_out=1010, Source1_out=11111, Source2_out=01110, OffsetScale_out=11, Destination_out=11011, MinorOpcode_out=1001, HasAddress_out=1, OffsetSub_out=1, Address_out=98.
REQ-029 Back-to-back words 0x10000000 and 0x20000000, no address -> Valid_out=1 for two consecutive cycles with MajorOpcode_out 1 then 2, and no bubble.
REQ-030 Backpressure: iq_full=1 while Valid_out=1 -> fetch_stall=1, outputs held and the word not consumed; after iq_full falls, the stalled word appears one cycle later.
REQ-031 Reserved opcode: 300 words 0xF0000000 -> Valid_out stays 0 and DropCount_out=255.
REQ-032 Reset after 0xAFBBDCE0 and 0x00000000 -> after release, word 0x30000000 decodes as major=3, Address_out=0 and HasAddress_out=0.
REQ-033 Gapped extension: base word, 3 idle cycles, hi word, 2 idle cycles, lo word -> Valid_out rises exactly one cycle after the lo word with the correct Address_out.
